// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out transmitter. A word is taken through a valid/ready
// load handshake. It is then sent one bit per accepted beat on a valid/ready
// serial port. done pulses for one cycle after the final bit is accepted.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; load_ready high; a load_valid edge captures a word
// SHIFT | word in flight; ser_valid high; each accepted beat moves one bit

module piso_shift_register #(
    parameter int N         = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_out,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [N-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic             done_r;
    logic             out_bit;
    logic [N-1:0]     shreg_next;

    // Bit presented at the output end, and the word after one bit leaves it.
    always_comb begin
        out_bit    = LSB_FIRST ? shreg[0] : shreg[N-1];
        shreg_next = LSB_FIRST ? {1'b0, shreg[N-1:1]} : {shreg[N-2:0], 1'b0};
    end

    // Handshake FSM: capture on load, shift on accepted beats, flag the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= load_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        if (cnt == CNT_LAST) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            done_r <= 1'b1;
                        end else begin
                            shreg <= shreg_next;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come from registered state only; rst forces them quiet.
    always_comb begin
        load_ready = (state == IDLE) && !rst;
        ser_valid  = (state == SHIFT) && !rst;
        busy       = (state == SHIFT) && !rst;
        ser_out    = (state == SHIFT) && !rst && out_bit;
        done       = done_r;
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register. Two instances share their inputs:
// one sends LSB first, the other MSB first.

module tb_piso_shift_register;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        ser_ready = 1'b1;

    logic load_ready_l, ser_valid_l, ser_out_l, busy_l, done_l;
    logic load_ready_m, ser_valid_m, ser_out_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_shift_register #(.N(16), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready_l), .load_data(load_data),
        .ser_valid(ser_valid_l), .ser_ready(ser_ready), .ser_out(ser_out_l),
        .busy(busy_l), .done(done_l)
    );

    piso_shift_register #(.N(16), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready_m), .load_data(load_data),
        .ser_valid(ser_valid_m), .ser_ready(ser_ready), .ser_out(ser_out_m),
        .busy(busy_m), .done(done_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    // Drives ser_ready from a stall mask (bit k set = stall on cycle k) and
    // collects the LSB-first instance's output until its done pulse.
    task automatic run_word(input logic [63:0] stall, output logic [15:0] word,
                            output int beats, output int shift_cyc,
                            output logic [63:0] so_h, output logic [63:0] sv_h,
                            output bit got_done);
        word = '0; beats = 0; shift_cyc = 0; so_h = '0; sv_h = '0; got_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            ser_ready = ~stall[k];
            so_h[k] = ser_out_l;
            sv_h[k] = ser_valid_l;
            if (busy_l) shift_cyc++;
            if (ser_valid_l && ser_ready) begin
                if (beats < 16) word[beats[3:0]] = ser_out_l;
                beats++;
            end
            tick();
            if (done_l) begin
                got_done = 1'b1;
                break;
            end
        end
        ser_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({load_ready_l, ser_valid_l, ser_out_l, busy_l, done_l} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {load_ready_l, ser_valid_l, ser_out_l, busy_l, done_l});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (load_ready_l !== 1'b1 || ser_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL reset_release load_ready=%b ser_valid=%b want 1 0",
                     load_ready_l, ser_valid_l);
        end
    endtask

    task automatic test_lsb_first();
        bit exp_seq [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
        int bad = 0;
        int valid_cnt = 0;
        ser_ready = 1'b1;
        load_word(16'hA5C3);
        for (int i = 0; i < 16; i++) begin
            if (ser_valid_l) valid_cnt++;
            if (ser_out_l !== exp_seq[i] || done_l !== 1'b0 || load_ready_l !== 1'b0) begin
                bad++;
                $display("FAIL lsb_bit%0d got=%b want=%b done=%b load_ready=%b",
                         i, ser_out_l, exp_seq[i], done_l, load_ready_l);
            end
            tick();
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (valid_cnt != 16) begin
            errors++;
            $display("FAIL lsb_valid_cycles got=%0d want=16", valid_cnt);
        end
        checks++;
        if (done_l !== 1'b1 || load_ready_l !== 1'b1 || ser_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL lsb_done_cycle done=%b load_ready=%b ser_valid=%b want 1 1 0",
                     done_l, load_ready_l, ser_valid_l);
        end
        tick();
        checks++;
        if (done_l !== 1'b0) begin
            errors++;
            $display("FAIL lsb_done_width got=%b want=0", done_l);
        end
    endtask

    task automatic test_msb_first();
        int bad = 0;
        int done_cnt = 0;
        logic exp_bit;
        ser_ready = 1'b1;
        load_word(16'h8001);
        for (int i = 0; i < 16; i++) begin
            exp_bit = (i == 0 || i == 15);
            if (ser_out_m !== exp_bit || ser_valid_m !== 1'b1) begin
                bad++;
                $display("FAIL msb_bit%0d got=%b want=%b valid=%b", i, ser_out_m, exp_bit, ser_valid_m);
            end
            tick();
        end
        checks++;
        if (bad != 0) errors++;
        for (int i = 0; i < 4; i++) begin
            if (done_m) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL msb_done_pulses got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] word;
        int beats, shift_cyc;
        logic [63:0] so_h, sv_h;
        bit got_done;
        load_word(16'h00FF);
        run_word(64'h1C, word, beats, shift_cyc, so_h, sv_h, got_done);
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL bp_timeout no done within budget");
        end
        checks++;
        if (so_h[4:2] !== 3'b111 || so_h[5] !== 1'b1 || sv_h[5:2] !== 4'b1111) begin
            errors++;
            $display("FAIL bp_hold ser_out=%b ser_valid=%b want 1111 1111", so_h[5:2], sv_h[5:2]);
        end
        checks++;
        if (shift_cyc != 19) begin
            errors++;
            $display("FAIL bp_shift_cycles got=%0d want=19", shift_cyc);
        end
        checks++;
        if (word !== 16'h00FF || beats != 16) begin
            errors++;
            $display("FAIL bp_word got=%h beats=%0d want=00ff 16", word, beats);
        end
        tick();
    endtask

    task automatic test_load_during_shift();
        logic [15:0] word = '0;
        int bad = 0;
        int beats, shift_cyc;
        logic [63:0] so_h, sv_h;
        bit got_done;
        ser_ready = 1'b1;
        load_word(16'h0F0F);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                load_valid = 1'b1;
                load_data  = 16'h1234;
            end
            if (i >= 4 && load_ready_l !== 1'b0) begin
                bad++;
                $display("FAIL lds_load_ready cycle%0d got=%b want=0", i, load_ready_l);
            end
            word[i] = ser_out_l;
            tick();
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (word !== 16'h0F0F) begin
            errors++;
            $display("FAIL lds_first_word got=%h want=0f0f", word);
        end
        checks++;
        if (done_l !== 1'b1 || load_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL lds_done_cycle done=%b load_ready=%b want 1 1", done_l, load_ready_l);
        end
        tick();
        load_valid = 1'b0;
        checks++;
        if (busy_l !== 1'b1 || ser_valid_l !== 1'b1 || done_l !== 1'b0 || ser_out_l !== 1'b0) begin
            errors++;
            $display("FAIL lds_capture busy=%b valid=%b done=%b out=%b want 1 1 0 0",
                     busy_l, ser_valid_l, done_l, ser_out_l);
        end
        run_word(64'h0, word, beats, shift_cyc, so_h, sv_h, got_done);
        checks++;
        if (!got_done || word !== 16'h1234 || shift_cyc != 16) begin
            errors++;
            $display("FAIL lds_second_word got=%h cycles=%0d done=%b want 1234 16 1",
                     word, shift_cyc, got_done);
        end
        tick();
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] word;
        int beats, shift_cyc;
        logic [63:0] so_h, sv_h;
        bit got_done;
        ser_ready = 1'b1;
        load_word(16'h5A5A);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({load_ready_l, ser_valid_l, busy_l, done_l} !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_in_reset got=%b want=0000",
                     {load_ready_l, ser_valid_l, busy_l, done_l});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({load_ready_l, ser_valid_l, busy_l, done_l} !== 4'b1000) begin
            errors++;
            $display("FAIL rmid_after got=%b want=1000",
                     {load_ready_l, ser_valid_l, busy_l, done_l});
        end
        load_word(16'hFFFF);
        run_word(64'h0, word, beats, shift_cyc, so_h, sv_h, got_done);
        checks++;
        if (!got_done || word !== 16'hFFFF || beats != 16 || so_h[15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL rmid_new_word got=%h beats=%0d done=%b want ffff 16 1",
                     word, beats, got_done);
        end
        tick();
    endtask

    task automatic test_toggle_stall();
        logic [15:0] word;
        int beats, shift_cyc;
        int extra_done = 0;
        int extra_valid = 0;
        logic [63:0] so_h, sv_h;
        bit got_done;
        load_word(16'h3C5A);
        run_word(64'hAAAA_AAAA_AAAA_AAAA, word, beats, shift_cyc, so_h, sv_h, got_done);
        checks++;
        if (!got_done || beats != 16 || word !== 16'h3C5A) begin
            errors++;
            $display("FAIL toggle_beats got=%0d word=%h done=%b want 16 3c5a 1",
                     beats, word, got_done);
        end
        checks++;
        if (shift_cyc != 31) begin
            errors++;
            $display("FAIL toggle_shift_cycles got=%0d want=31", shift_cyc);
        end
        for (int i = 0; i < 3; i++) begin
            if (ser_valid_l) extra_valid++;
            tick();
            if (done_l) extra_done++;
        end
        checks++;
        if (extra_valid != 0 || extra_done != 0) begin
            errors++;
            $display("FAIL toggle_tail extra_valid=%0d extra_done=%0d want 0 0",
                     extra_valid, extra_done);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_load_during_shift();
        test_reset_mid_word();
        test_toggle_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in, serial-out transmitter. It is the unloading counterpart of the team's N-bit parallel-capture register.
- Accepts one N-bit word through a valid/ready load handshake.
- Emits the word one bit per accepted beat on a valid/ready serial output.
- Sits between a parallel datapath register and a serial link or bit-serial consumer.

Parameters:
- N, 16, word width in bits; legal range N >= 2.
- LSB_FIRST, 1, bit order: 1 = bit 0 first, 0 = bit N-1 first.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  load_data holds a word to send.
- load_ready  output  1  block can accept a word.
- load_data  input  N  parallel word.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream accepts the current bit.
- ser_out  output  1  current serial bit.
- busy  output  1  a word is being shifted out.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- State machine has two states, IDLE and SHIFT.
- Internal registers:
  - shreg[N-1:0]
  - cnt, width $clog2(N), counting accepted bits 0..N-1
  - state
  - done_r
- Reset, with rst high at a clock edge:
  - state=IDLE, shreg=0, cnt=0, done=0.
  - While rst is high, load_ready=0, ser_valid=0, ser_out=0, busy=0.
  - Reset mid-word abandons the word; no done pulse is produced.
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0, busy=0.
  - If load_valid=1 at the edge: shreg<=load_data, cnt<=0, state<=SHIFT.
  - If load_valid=0, nothing changes.
- SHIFT:
  - load_ready=0, ser_valid=1, busy=1.
  - ser_out=shreg[0] when LSB_FIRST=1, else shreg[N-1].
  - A beat is accepted when ser_valid=1 and ser_ready=1 at the edge.
  - On an accepted beat with cnt<N-1:
    - shreg shifts toward the output end (right when LSB_FIRST=1, left otherwise), with 0 filled in.
    - cnt<=cnt+1.
  - On an accepted beat with cnt==N-1: state<=IDLE, cnt<=0, done_r<=1.
  - While ser_ready=0, shreg, cnt and ser_out hold stable; ser_valid stays 1 (no retraction).
- done:
  - Registered; high exactly the one cycle after the final accepted beat (the first IDLE cycle), then 0.
  - done is not affected by a new load in that cycle.
- Latency and throughput:
  - The first bit is valid the cycle after the load handshake.
  - With ser_ready held at 1, a word takes N cycles in SHIFT.
  - Minimum load-to-load spacing is N+1 cycles, because load_ready is asserted in the done cycle.
- Loads attempted in SHIFT (load_valid=1 while load_ready=0) are ignored. Upstream must hold load_valid and load_data until load_ready.
- ser_out is a direct function of registered state with no combinational path from ser_ready. load_ready depends only on state and rst.

Test Plan:
- Reset then load, N=16, LSB_FIRST=1, load_data=16'hA5C3, ser_ready=1 -> ser_out sequence over 16 cycles is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; ser_valid high for exactly 16 cycles; done high on cycle 17 only; load_ready returns 1 on cycle 17.
- LSB_FIRST=0, load_data=16'h8001 -> first bit 1, then 14 zeros, then 1; done pulses once.
- Backpressure: load 16'h00FF, drop ser_ready for 3 cycles after bit 2 -> ser_out and ser_valid hold during the stall; total SHIFT cycles = 19; the received word equals 16'h00FF.
- Load during SHIFT: assert load_valid with 16'h1234 mid-word -> load_ready=0 and the current word is unaffected. Holding load_valid results in 16'h1234 being captured in the done cycle, and its first bit appears the next cycle.
- Reset mid-word after 5 accepted bits -> next cycle ser_valid=0, busy=0, done=0, load_ready=1 (once rst is low); a new word 16'hFFFF then shifts out cleanly as 16 ones.
- Zero-length stall corner: ser_ready toggling 1,0,1,0 across the whole word -> exactly 16 accepted beats, one done pulse, no extra ser_valid cycle after the last accepted bit.
